shift_seq: RTL

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/shift_seq.sv
// Multi-cycle shifter/rotator: shifts a by an effective count of b, moving
// BIG_STEP bits per cycle while possible and single bits for the remainder.
module shift_seq #(
  parameter int unsigned BIG_STEP = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        ready,
  output logic        illegal
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 6;
  localparam int unsigned SW = 4;

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   work_q, work_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [2:0]      op_q, op_d;
  logic            sign_q, sign_d;
  logic            illegal_d;
  logic            done_q, busy_q, ready_q, illegal_q;

  logic [CW-1:0]   count_c;
  logic [SW-1:0]   step_c;

  // Shift distances and rotates saturate at 32 or wrap to 0..31 respectively.
  function automatic logic [CW-1:0] eff_count(input logic [2:0] o, input logic [DW-1:0] amt);
    logic [CW-1:0] n;
    n = '0;
    case (o)
      OP_SHR, OP_SHRA, OP_SHL: n = (amt > 32'd32) ? CW'(32) : CW'(amt);
      OP_ROR, OP_ROL:          n = {1'b0, amt[4:0]};
      default:                 n = '0;
    endcase
    return n;
  endfunction

  // One shift cycle; SHRA fills from the sign captured at accept time.
  function automatic logic [DW-1:0] shift_step(input logic [DW-1:0] w, input logic [2:0] o,
                                               input logic sgn, input logic [SW-1:0] amt);
    logic [2*DW-1:0] ext;
    logic [DW-1:0]   r;
    ext = '0;
    r   = w;
    case (o)
      OP_SHR:  r = w >> amt;
      OP_SHRA: begin
        ext = {{DW{sgn}}, w} >> amt;
        r   = ext[DW-1:0];
      end
      OP_SHL:  r = w << amt;
      OP_ROR:  begin
        ext = {w, w} >> amt;
        r   = ext[DW-1:0];
      end
      OP_ROL:  begin
        ext = {w, w} << amt;
        r   = ext[2*DW-1:DW];
      end
      default: r = w;
    endcase
    return r;
  endfunction

  assign count_c = eff_count(op, b);
  assign step_c  = (rem_q >= CW'(BIG_STEP)) ? SW'(BIG_STEP) : SW'(1);

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    rem_d     = rem_q;
    op_d      = op_q;
    sign_d    = sign_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d      = op;
          work_d    = a;
          sign_d    = a[DW-1];
          rem_d     = count_c;
          illegal_d = (op > OP_ROL);
          state_d   = (count_c == '0) ? DONE : SHIFT;
        end else begin
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        work_d = shift_step(work_q, op_q, sign_q, step_c);
        rem_d  = rem_q - CW'(step_c);
        if (rem_d == '0) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      work_q    <= '0;
      rem_q     <= '0;
      op_q      <= '0;
      sign_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      rem_q     <= rem_d;
      op_q      <= op_d;
      sign_q    <= sign_d;
      done_q    <= (state_d == DONE);
      busy_q    <= (state_d == SHIFT);
      ready_q   <= (state_d != SHIFT);
      illegal_q <= illegal_d;
    end
  end

  assign result  = work_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign ready   = ready_q;
  assign illegal = illegal_q;

endmodule
